// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and helpers for the multi-port register file
//
// Purpose: clear-sweep FSM encoding, default geometry and the address
// validity check shared by the top and the busy scoreboard.
package rf_pkg;

  localparam int RF_WIDTH_DEF = 32;
  localparam int RF_DEPTH_DEF = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  // An address is usable when it lies inside the array and is not the
  // hardwired zero register.
  function automatic bit rf_addr_ok(input int unsigned addr,
                                    input int unsigned depth,
                                    input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits for long-latency writebacks
//
// Purpose: DEPTH busy bits with set (reserve), clear (writeback) and
// sweep-clear, plus NRD lookup ports.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   set_en, set_addr     mark a register busy (already qualified by caller)
//   clr_en, clr_addr     clear a busy bit (already qualified by caller)
//   sweep_en, sweep_addr clear-sweep clear of one bit
//   look_addr            NRD packed lookup addresses
//   look_busy            NRD busy flags, same-cycle clear bypassed
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            sweep_en,
  input  logic [AW-1:0]   sweep_addr,
  input  logic [NRD*AW-1:0] look_addr,
  output logic [NRD-1:0]  look_busy
);

  logic [DEPTH-1:0] busy_q, busy_d;

  // Reserve is applied last so a same-cycle reserve beats a writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (sweep_en) busy_d[sweep_addr] = 1'b0;
    if (clr_en)   busy_d[clr_addr]   = 1'b0;
    if (set_en)   busy_d[set_addr]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookups see a writeback clear immediately but a reserve only next cycle.
  for (genvar k = 0; k < NRD; k++) begin : g_look
    logic [AW-1:0] a;
    assign a = look_addr[k*AW +: AW];
    assign look_busy[k] = rf_addr_ok(32'(a), DEPTH, 1'b0) && busy_q[a] &&
                          !(clr_en && (clr_addr == a));
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, scoreboard and clear sweep
//
// Purpose: NRD combinational read ports, two prioritised write ports with
// write-through bypass, busy scoreboard and a sequential clear engine.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_addr / rd_data / rd_busy NRD packed read ports (combinational)
//   w0_en/w0_addr/w0_data      ALU writeback, wins on address collision
//   w1_en/w1_addr/w1_data      long-latency writeback, clears busy
//   rsv_en/rsv_addr            reserve (set busy) at issue
//   clr_req                    start clear sweep
//   clr_busy / clr_done        sweep in progress / last sweep cycle
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH_DEF,
  parameter  int DEPTH    = RF_DEPTH_DEF,
  parameter  int NRD      = 2,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 w0_en,
  input  logic [AW-1:0]        w0_addr,
  input  logic [WIDTH-1:0]     w0_data,
  input  logic                 w1_en,
  input  logic [AW-1:0]        w1_addr,
  input  logic [WIDTH-1:0]     w1_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             sweep_active;
  logic             w0_we, w1_we, w1_clr, rsv_we;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_SWEEP;
          cnt_d   = '0;
        end
      end
      RF_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH-1)) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sweep_active = 1'b0;
    clr_busy     = 1'b0;
    clr_done     = 1'b0;
    if (state_q == RF_SWEEP) begin
      sweep_active = 1'b1;
      clr_busy     = 1'b1;
      clr_done     = (cnt_q == AW'(DEPTH-1));
    end
  end

  // All updates are locked out while the sweep owns the array. Port 1 loses
  // the data write on a collision but still retires its busy bit.
  assign w0_we  = !sweep_active && w0_en && rf_addr_ok(32'(w0_addr), DEPTH, ZERO_REG);
  assign w1_clr = !sweep_active && w1_en && rf_addr_ok(32'(w1_addr), DEPTH, ZERO_REG);
  assign w1_we  = w1_clr && !(w0_we && (w0_addr == w1_addr));
  assign rsv_we = !sweep_active && rsv_en && rf_addr_ok(32'(rsv_addr), DEPTH, ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (sweep_active) mem_q[cnt_q]   <= '0;
      if (w0_we)        mem_q[w0_addr] <= w0_data;
      if (w1_we)        mem_q[w1_addr] <= w1_data;
    end
  end

  // Bypass uses the qualified enables, so it is naturally off during a sweep.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok;
    assign a  = rd_addr[k*AW +: AW];
    assign ok = rf_addr_ok(32'(a), DEPTH, ZERO_REG);
    assign rd_data[k*WIDTH +: WIDTH] = !ok                        ? '0      :
                                       (w0_we && (w0_addr == a)) ? w0_data :
                                       (w1_we && (w1_addr == a)) ? w1_data :
                                                                   mem_q[a];
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (rsv_we),
    .set_addr   (rsv_addr),
    .clr_en     (w1_clr),
    .clr_addr   (w1_addr),
    .sweep_en   (sweep_active),
    .sweep_addr (cnt_q),
    .look_addr  (rd_addr),
    .look_busy  (rd_busy)
  );

endmodule
